// File: rtl/mips_dmem_responder.sv
// MEM-stage data-memory responder: fixed wait states, MemStall handshake, word-addressed RAM.
// Optional access-error checking is enabled by defining MEM_ERR_EN.
module mips_dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemStall,
  output logic        MemErr
);

  // state  | meaning
  // S_IDLE | waiting for a request; stalls combinationally when one arrives
  // S_BUSY | wait states counting down, stall held
  // S_DONE | access completes, stall released for one cycle
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                 r_state, w_next;
  logic [3:0]             r_cnt;
  logic                   r_wr, r_rd, r_err;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [31:0]            r_data;
  logic [31:0]            r_mem [DEPTH];

  logic                   w_req, w_in_idle, w_stall, w_enter_done;
  logic                   w_wr, w_rd, w_err, w_addr_err;
  logic [ADDR_BITS-1:0]   w_idx;
  logic [31:0]            w_data;
  logic                   w_unused_addr;

  assign w_req     = MemRead | MemWrite;
  assign w_in_idle = (r_state == S_IDLE);

`ifdef MEM_ERR_EN
  assign w_addr_err = (|Address[1:0]) | (|Address[31:ADDR_BITS+2]);
`else
  assign w_addr_err = 1'b0;
`endif
  assign w_unused_addr = ^{Address[31:ADDR_BITS+2], Address[1:0]};

  // With WAIT_CYCLES==1 the access completes straight out of IDLE, so the
  // commit path must see the live request rather than the latched copy.
  assign w_wr   = w_in_idle ? MemWrite   : r_wr;
  assign w_rd   = w_in_idle ? MemRead    : r_rd;
  assign w_idx  = w_in_idle ? Address[ADDR_BITS+1:2] : r_idx;
  assign w_data = w_in_idle ? WriteData  : r_data;
  assign w_err  = w_in_idle ? w_addr_err : r_err;

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          w_next  = (WAIT_CYCLES == 1) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd1) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_done = (w_next == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_data   <= 32'd0;
      ReadData <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_in_idle && w_req) begin
        r_wr   <= MemWrite;
        r_rd   <= MemRead;
        r_err  <= w_addr_err;
        r_idx  <= Address[ADDR_BITS+1:2];
        r_data <= WriteData;
        r_cnt  <= LP_CNT_INIT;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A combined read/write is treated as a write only.
      if (w_enter_done && w_rd && !w_wr)
        ReadData <= w_err ? 32'hDEAD_BEEF : r_mem[w_idx];
    end
  end

  // Reset on the commit edge discards the pending write.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_done && w_wr && !w_err)
      r_mem[w_idx] <= w_data;
  end

  assign MemStall = w_stall & ~rst;
  assign MemErr   = (r_state == S_DONE) & r_err;

endmodule
